// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage and the data memory.
//   master (MEM stage): drives DMEM_Addr_OUT, DMEM_WData_OUT, DMEM_ByteEn_OUT,
//                       DMEM_Req_OUT, DMEM_We_OUT; receives DMEM_RData_IN, DMEM_Ack_IN
//   slave  (memory)   : the mirror image
interface mem_access_if;
  logic [31:0] DMEM_Addr_OUT;
  logic [31:0] DMEM_WData_OUT;
  logic [3:0]  DMEM_ByteEn_OUT;
  logic        DMEM_Req_OUT;
  logic        DMEM_We_OUT;
  logic [31:0] DMEM_RData_IN;
  logic        DMEM_Ack_IN;

  modport master (
    output DMEM_Addr_OUT, DMEM_WData_OUT, DMEM_ByteEn_OUT, DMEM_Req_OUT, DMEM_We_OUT,
    input  DMEM_RData_IN, DMEM_Ack_IN
  );

  modport slave (
    input  DMEM_Addr_OUT, DMEM_WData_OUT, DMEM_ByteEn_OUT, DMEM_Req_OUT, DMEM_We_OUT,
    output DMEM_RData_IN, DMEM_Ack_IN
  );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: issues loads/stores on the data-memory bus, stalls the
// pipe while a request is outstanding, aborts after TIMEOUT_CYCLES stalled
// cycles, and registers the writeback bundle for WB.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-low reset
//   *1_IN                 instruction bundle from EXE (held while Stall_OUT=1)
//   dmem                  data-memory bus (master side)
//   Instr1_OUT .. RegWrite1_OUT  registered writeback bundle
//   Mem_result_forward    copy of WriteData1_OUT for EXE forwarding
//   Stall_OUT             combinational stall request to upstream stages
//   Misaligned_OUT        one-cycle pulse after a rejected misaligned access
//   Error_OUT             sticky bus-timeout flag
//
// state  | meaning
// S_IDLE | no request outstanding; an aligned memory op is issued this cycle
// S_WAIT | request issued, waiting for DMEM_Ack_IN or timeout
module mem_access #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         Instr1_IN,
  input  logic [31:0]         Instr1_PC_IN,
  input  logic [31:0]         ALU_result1_IN,
  input  logic [4:0]          WriteRegister1_IN,
  input  logic [31:0]         MemWriteData1_IN,
  input  logic                RegWrite1_IN,
  input  logic                MemRead1_IN,
  input  logic                MemWrite1_IN,
  input  logic [5:0]          ALU_Control1_IN,
  mem_access_if.master        dmem,
  output logic [31:0]         Instr1_OUT,
  output logic [31:0]         Instr1_PC_OUT,
  output logic [31:0]         WriteData1_OUT,
  output logic [4:0]          WriteRegister1_OUT,
  output logic                RegWrite1_OUT,
  output logic [31:0]         Mem_result_forward,
  output logic                Stall_OUT,
  output logic                Misaligned_OUT,
  output logic                Error_OUT
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  // The request cycle in IDLE is the first stalled cycle, so WAIT aborts
  // once TIMEOUT_CYCLES-1 further cycles have gone by without an ack.
  localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        req, stall, abort;

  logic [1:0]  a;
  logic        mem_op, is_byte, is_half, sext, misaligned;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  logic        unused_ctrl;
  assign unused_ctrl = ^ALU_Control1_IN[5:3];

  assign a      = ALU_result1_IN[1:0];
  assign mem_op = MemRead1_IN | MemWrite1_IN;

  always_comb begin
    is_byte = 1'b0;
    is_half = 1'b0;
    sext    = 1'b0;
    case (ALU_Control1_IN[2:0])
      3'b001:  begin is_byte = 1'b1; sext = 1'b1; end
      3'b010:  is_byte = 1'b1;
      3'b011:  begin is_half = 1'b1; sext = 1'b1; end
      3'b100:  is_half = 1'b1;
      default: ;
    endcase
  end

  assign misaligned = mem_op & ((is_half & a[0]) | (~is_byte & ~is_half & (a != 2'b00)));

  // Store lanes: data is replicated so the memory only needs the byte enables.
  always_comb begin
    be    = 4'b1111;
    wdata = MemWriteData1_IN;
    if (is_byte) begin
      be    = 4'b0001 << a;
      wdata = {4{MemWriteData1_IN[7:0]}};
    end else if (is_half) begin
      be    = a[1] ? 4'b1100 : 4'b0011;
      wdata = {2{MemWriteData1_IN[15:0]}};
    end
  end

  always_comb begin
    case (a)
      2'd0:    ld_byte = dmem.DMEM_RData_IN[7:0];
      2'd1:    ld_byte = dmem.DMEM_RData_IN[15:8];
      2'd2:    ld_byte = dmem.DMEM_RData_IN[23:16];
      default: ld_byte = dmem.DMEM_RData_IN[31:24];
    endcase
    ld_half = a[1] ? dmem.DMEM_RData_IN[31:16] : dmem.DMEM_RData_IN[15:0];
    ld_val  = dmem.DMEM_RData_IN;
    if (is_byte)
      ld_val = {{24{sext & ld_byte[7]}}, ld_byte};
    else if (is_half)
      ld_val = {{16{sext & ld_half[15]}}, ld_half};
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req       = 1'b0;
    stall     = 1'b0;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_op && !misaligned) begin
          req = 1'b1;
          if (!dmem.DMEM_Ack_IN) begin
            stall     = 1'b1;
            state_nxt = S_WAIT;
            cnt_nxt   = 8'd0;
          end
        end
      end
      S_WAIT: begin
        if (cnt == TC_LAST) begin
          // Timeout wins over a coincident ack: the request is already withdrawn.
          abort     = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          req = 1'b1;
          if (dmem.DMEM_Ack_IN) begin
            state_nxt = S_IDLE;
          end else begin
            stall   = 1'b1;
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Req/Stall are gated by RESET so they drop the instant reset asserts.
  assign dmem.DMEM_Req_OUT    = req & RESET;
  assign dmem.DMEM_We_OUT     = req & RESET & MemWrite1_IN;
  assign dmem.DMEM_ByteEn_OUT = (req & RESET) ? be : 4'b0000;
  assign dmem.DMEM_Addr_OUT   = {ALU_result1_IN[31:2], 2'b00};
  assign dmem.DMEM_WData_OUT  = wdata;
  assign Stall_OUT            = stall & RESET;
  assign Mem_result_forward   = WriteData1_OUT;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      Instr1_OUT         <= 32'd0;
      Instr1_PC_OUT      <= 32'd0;
      WriteData1_OUT     <= 32'd0;
      WriteRegister1_OUT <= 5'd0;
      RegWrite1_OUT      <= 1'b0;
      Misaligned_OUT     <= 1'b0;
      Error_OUT          <= 1'b0;
    end else begin
      Misaligned_OUT <= 1'b0;
      if (abort)
        Error_OUT <= 1'b1;
      if (stall || abort) begin
        // Bubble: WB sees a no-op, writeback value and register are kept.
        Instr1_OUT    <= 32'd0;
        Instr1_PC_OUT <= 32'd0;
        RegWrite1_OUT <= 1'b0;
      end else begin
        Instr1_OUT         <= Instr1_IN;
        Instr1_PC_OUT      <= Instr1_PC_IN;
        WriteRegister1_OUT <= WriteRegister1_IN;
        if (!mem_op) begin
          WriteData1_OUT <= ALU_result1_IN;
          RegWrite1_OUT  <= RegWrite1_IN;
        end else if (misaligned) begin
          RegWrite1_OUT  <= 1'b0;
          Misaligned_OUT <= 1'b1;
        end else if (MemWrite1_IN) begin
          RegWrite1_OUT  <= 1'b0;
        end else begin
          WriteData1_OUT <= ld_val;
          RegWrite1_OUT  <= RegWrite1_IN;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  localparam int TMO = 4;

  logic        CLK, RESET;
  logic [31:0] Instr1_IN, Instr1_PC_IN, ALU_result1_IN, MemWriteData1_IN;
  logic [4:0]  WriteRegister1_IN;
  logic        RegWrite1_IN, MemRead1_IN, MemWrite1_IN;
  logic [5:0]  ALU_Control1_IN;
  logic [31:0] Instr1_OUT, Instr1_PC_OUT, WriteData1_OUT, Mem_result_forward;
  logic [4:0]  WriteRegister1_OUT;
  logic        RegWrite1_OUT, Stall_OUT, Misaligned_OUT, Error_OUT;

  mem_access_if bus ();

  mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RESET(RESET),
    .Instr1_IN(Instr1_IN), .Instr1_PC_IN(Instr1_PC_IN),
    .ALU_result1_IN(ALU_result1_IN), .WriteRegister1_IN(WriteRegister1_IN),
    .MemWriteData1_IN(MemWriteData1_IN), .RegWrite1_IN(RegWrite1_IN),
    .MemRead1_IN(MemRead1_IN), .MemWrite1_IN(MemWrite1_IN),
    .ALU_Control1_IN(ALU_Control1_IN), .dmem(bus),
    .Instr1_OUT(Instr1_OUT), .Instr1_PC_OUT(Instr1_PC_OUT),
    .WriteData1_OUT(WriteData1_OUT), .WriteRegister1_OUT(WriteRegister1_OUT),
    .RegWrite1_OUT(RegWrite1_OUT), .Mem_result_forward(Mem_result_forward),
    .Stall_OUT(Stall_OUT), .Misaligned_OUT(Misaligned_OUT), .Error_OUT(Error_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: expected registered bundle, sticky error, and how many
  // cycles the current request has already been stalled.
  logic [31:0] m_instr, m_pc, m_wd;
  logic [4:0]  m_wr;
  logic        m_rw, m_mis, m_err;
  int          m_pend;

  // Observations used by the directed literal checks.
  int          mis_cnt;
  bit          req_seen;
  logic [3:0]  last_be;
  logic [31:0] last_wd;
  logic        last_we;

  initial begin
    m_instr = 0; m_pc = 0; m_wd = 0; m_wr = 0; m_rw = 0; m_mis = 0; m_err = 0; m_pend = 0;
    mis_cnt = 0; req_seen = 0; last_be = 0; last_wd = 0; last_we = 0;
  end

  always @(negedge CLK) begin : model
    logic [1:0]  a;
    logic [2:0]  sz;
    bit          mem, byt, hlf, sgn, mis, e_req, e_stall, abrt;
    logic [31:0] sh, ld, e_wd;
    logic [3:0]  e_be;

    if (!RESET) begin
      m_instr = 0; m_pc = 0; m_wd = 0; m_wr = 0; m_rw = 0; m_mis = 0; m_err = 0; m_pend = 0;
    end

    chk("instr_out", Instr1_OUT, m_instr);
    chk("pc_out", Instr1_PC_OUT, m_pc);
    chk("wdata_out", WriteData1_OUT, m_wd);
    chk("fwd_out", Mem_result_forward, m_wd);
    chk("wreg_out", {27'd0, WriteRegister1_OUT}, {27'd0, m_wr});
    chk("regwrite_out", {31'd0, RegWrite1_OUT}, {31'd0, m_rw});
    chk("misaligned_out", {31'd0, Misaligned_OUT}, {31'd0, m_mis});
    chk("error_out", {31'd0, Error_OUT}, {31'd0, m_err});
    if (Misaligned_OUT) mis_cnt++;

    a   = ALU_result1_IN[1:0];
    sz  = ALU_Control1_IN[2:0];
    mem = MemRead1_IN || MemWrite1_IN;
    byt = (sz == 3'd1) || (sz == 3'd2);
    hlf = (sz == 3'd3) || (sz == 3'd4);
    sgn = (sz == 3'd1) || (sz == 3'd3);
    mis = mem && (hlf ? a[0] : (!byt && a != 2'b00));

    e_req = 0; e_stall = 0; abrt = 0;
    if (RESET && mem && !mis) begin
      if (m_pend == TMO) abrt = 1;
      else begin
        e_req   = 1;
        e_stall = !bus.DMEM_Ack_IN;
      end
    end
    chk("req", {31'd0, bus.DMEM_Req_OUT}, {31'd0, e_req});
    chk("stall", {31'd0, Stall_OUT}, {31'd0, e_stall});
    if (e_req) begin
      if (byt) begin
        e_be = 4'b0001 << a;
        e_wd = {4{MemWriteData1_IN[7:0]}};
      end else if (hlf) begin
        e_be = 4'b0011 << (2 * a[1]);
        e_wd = {2{MemWriteData1_IN[15:0]}};
      end else begin
        e_be = 4'hF;
        e_wd = MemWriteData1_IN;
      end
      chk("addr", bus.DMEM_Addr_OUT, ALU_result1_IN & 32'hFFFF_FFFC);
      chk("we", {31'd0, bus.DMEM_We_OUT}, {31'd0, MemWrite1_IN});
      if (MemWrite1_IN) begin
        chk("byteen", {28'd0, bus.DMEM_ByteEn_OUT}, {28'd0, e_be});
        chk("wdata_bus", bus.DMEM_WData_OUT, e_wd);
      end
      req_seen = 1;
      last_be  = bus.DMEM_ByteEn_OUT;
      last_wd  = bus.DMEM_WData_OUT;
      last_we  = bus.DMEM_We_OUT;
    end

    // Prediction for the coming rising edge.
    if (RESET) begin
      m_mis = 0;
      if (e_stall || abrt) begin
        m_instr = 0; m_pc = 0; m_rw = 0;
        m_pend  = e_stall ? m_pend + 1 : 0;
        if (abrt) m_err = 1;
      end else begin
        m_pend  = 0;
        m_instr = Instr1_IN; m_pc = Instr1_PC_IN; m_wr = WriteRegister1_IN;
        if (!mem) begin
          m_wd = ALU_result1_IN; m_rw = RegWrite1_IN;
        end else if (mis) begin
          m_rw = 0; m_mis = 1;
        end else if (MemWrite1_IN) begin
          m_rw = 0;
        end else begin
          if (byt) begin
            sh = bus.DMEM_RData_IN >> (8 * a);
            ld = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'd0, sh[7:0]};
          end else if (hlf) begin
            sh = bus.DMEM_RData_IN >> (16 * a[1]);
            ld = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'd0, sh[15:0]};
          end else begin
            ld = bus.DMEM_RData_IN;
          end
          m_wd = ld; m_rw = RegWrite1_IN;
        end
      end
    end
  end

  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic drive(input logic rd, input logic wr, input logic rw, input logic [2:0] sz,
                       input logic [31:0] alu, input logic [31:0] wdat, input logic [31:0] rdat);
    Instr1_IN         = 32'h0000_0013 ^ (pc_ctr << 4);
    Instr1_PC_IN      = pc_ctr;
    WriteRegister1_IN = pc_ctr[6:2];
    pc_ctr            = pc_ctr + 32'd4;
    MemRead1_IN       = rd;
    MemWrite1_IN      = wr;
    RegWrite1_IN      = rw;
    ALU_Control1_IN   = {3'b101, sz};
    ALU_result1_IN    = alu;
    MemWriteData1_IN  = wdat;
    bus.DMEM_RData_IN = rdat;
  endtask

  // Holds the current inputs until the DUT stops stalling; ack arrives in
  // cycle ack_after (negative: never). Returns at posedge+1 after the
  // completing edge.
  task automatic run_op(input int ack_after, output int stalls, output bit req_end);
    bit done;
    stalls = 0; done = 0; req_end = 0; req_seen = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      bus.DMEM_Ack_IN = (k == ack_after);
      @(negedge CLK);
      req_end = bus.DMEM_Req_OUT;
      if (Stall_OUT) stalls++;
      else done = 1;
      @(posedge CLK); #1;
    end
    bus.DMEM_Ack_IN = 1'b0;
    chk("op_completes", {31'd0, done}, 32'd1);
  endtask

  task automatic nops(input int n);
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  int st;
  bit re;

  initial begin
    RESET = 1'b0;
    bus.DMEM_Ack_IN = 1'b0;
    drive(0, 0, 0, 3'd0, 32'h0, 32'h0, 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req", {31'd0, bus.DMEM_Req_OUT}, 32'd0);
    chk("rst_wdata", WriteData1_OUT, 32'd0);
    chk("rst_error", {31'd0, Error_OUT}, 32'd0);
    RESET = 1'b1;
    nops(2);

    // zero-wait lw
    drive(1, 0, 1, 3'd0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
    run_op(0, st, re);
    chk("lw_stalls", st, 0);
    chk("lw_req", {31'd0, re}, 32'd1);
    chk("lw_result", WriteData1_OUT, 32'hDEAD_BEEF);
    chk("lw_regwrite", {31'd0, RegWrite1_OUT}, 32'd1);

    // lb signed, ack after 3 cycles
    drive(1, 0, 1, 3'd1, 32'h0000_0103, 32'h0, 32'h8012_3456);
    run_op(3, st, re);
    chk("lb_stalls", st, 3);
    chk("lb_result", WriteData1_OUT, 32'hFFFF_FF80);

    drive(1, 0, 1, 3'd2, 32'h0000_0101, 32'h0, 32'h0000_A500);
    run_op(1, st, re);
    chk("lbu_result", WriteData1_OUT, 32'h0000_00A5);
    drive(1, 0, 1, 3'd3, 32'h0000_0102, 32'h0, 32'h8001_7777);
    run_op(0, st, re);
    chk("lh_result", WriteData1_OUT, 32'hFFFF_8001);
    drive(1, 0, 1, 3'd4, 32'h0000_0100, 32'h0, 32'h1234_BEEF);
    run_op(2, st, re);
    chk("lhu_result", WriteData1_OUT, 32'h0000_BEEF);

    // stores
    drive(0, 1, 1, 3'd3, 32'h0000_0202, 32'h1234_ABCD, 32'h0);
    run_op(0, st, re);
    chk("sh_be", {28'd0, last_be}, 32'h0000_000C);
    chk("sh_wdata", last_wd, 32'hABCD_ABCD);
    chk("sh_we", {31'd0, last_we}, 32'd1);
    chk("sh_regwrite", {31'd0, RegWrite1_OUT}, 32'd0);
    drive(0, 1, 0, 3'd1, 32'h0000_0201, 32'h0000_995A, 32'h0);
    run_op(2, st, re);
    chk("sb_be", {28'd0, last_be}, 32'h0000_0002);
    chk("sb_wdata", last_wd, 32'h5A5A_5A5A);

    // misaligned lw
    mis_cnt = 0;
    drive(1, 0, 1, 3'd0, 32'h0000_0101, 32'h0, 32'h1111_1111);
    run_op(0, st, re);
    chk("mis_req_seen", {31'd0, req_seen}, 32'd0);
    chk("mis_regwrite", {31'd0, RegWrite1_OUT}, 32'd0);
    nops(3);
    chk("mis_pulses", mis_cnt, 1);

    // non-memory pass-through
    drive(0, 0, 1, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
    run_op(-1, st, re);
    chk("alu_stalls", st, 0);
    chk("alu_result", WriteData1_OUT, 32'h1234_5678);

    // timeout
    drive(1, 0, 1, 3'd0, 32'h0000_0300, 32'h0, 32'h0);
    run_op(-1, st, re);
    chk("tmo_stalls", st, TMO);
    chk("tmo_req_dropped", {31'd0, re}, 32'd0);
    chk("tmo_error", {31'd0, Error_OUT}, 32'd1);
    nops(3);
    chk("tmo_error_sticky", {31'd0, Error_OUT}, 32'd1);

    // reset in the middle of WAIT, then a late ack
    drive(1, 0, 1, 3'd0, 32'h0000_0400, 32'h0, 32'h0);
    bus.DMEM_Ack_IN = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    chk("wait_stall", {31'd0, Stall_OUT}, 32'd1);
    RESET = 1'b0;
    #1;
    chk("rst_mid_req", {31'd0, bus.DMEM_Req_OUT}, 32'd0);
    chk("rst_mid_stall", {31'd0, Stall_OUT}, 32'd0);
    chk("rst_mid_error", {31'd0, Error_OUT}, 32'd0);
    @(posedge CLK); #1;
    bus.DMEM_Ack_IN = 1'b1;
    @(posedge CLK); #1;
    bus.DMEM_Ack_IN = 1'b0;
    drive(0, 0, 1, 3'd0, 32'h0000_0005, 32'h0, 32'h0);
    RESET = 1'b1;
    run_op(-1, st, re);
    chk("addu_stalls", st, 0);
    chk("addu_result", WriteData1_OUT, 32'h0000_0005);
    nops(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
